// File: rtl/mux_tr_seq_ctrl.sv
// Sequencer for the registered n:1 transfer mux: drives select/load so entries 0..len-1
// appear in order behind a valid/ready handshake. Optional MUX_TR_CYCLE_EN adds cycle_i (wrap-around runs).
module mux_tr_seq_ctrl #(
  parameter int LEN_TRANSFER     = 8,
  parameter int MAX_LEN_TRANSFER = 8,
  parameter int SEL_MUX_TR_WIDTH = $clog2(MAX_LEN_TRANSFER),
  parameter int LEN_WIDTH        = $clog2(LEN_TRANSFER + 1)
) (
  input  logic                        clk_i,
  input  logic                        sel_mux_tr_rst_i,
  input  logic                        start_i,
  input  logic [LEN_WIDTH-1:0]        len_i,
  input  logic                        abort_i,
  input  logic                        tr_ready_i,
`ifdef MUX_TR_CYCLE_EN
  input  logic                        cycle_i,
`endif
  output logic [SEL_MUX_TR_WIDTH-1:0] sel_mux_tr_o,
  output logic                        sel_mux_tr_ld_o,
  output logic                        tr_valid_o,
  output logic [SEL_MUX_TR_WIDTH-1:0] tr_idx_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(LEN_TRANSFER);

  state_t                      state_q, state_d;
  logic [SEL_MUX_TR_WIDTH-1:0] idx_q, idx_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [SEL_MUX_TR_WIDTH-1:0] idx_inc;
  logic [LEN_WIDTH-1:0]        len_m1;
  logic                        idx_at_last;
`ifdef MUX_TR_CYCLE_EN
  logic                        cycle_q, cycle_d;
`endif

  assign idx_inc     = idx_q + SEL_MUX_TR_WIDTH'(1);
  assign len_m1      = len_q - LEN_WIDTH'(1);
  assign idx_at_last = (LEN_WIDTH'(idx_q) == len_m1);

  always_ff @(posedge clk_i or posedge sel_mux_tr_rst_i) begin
    if (sel_mux_tr_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
`ifdef MUX_TR_CYCLE_EN
      cycle_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
`ifdef MUX_TR_CYCLE_EN
      cycle_q <= cycle_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    len_d           = len_q;
`ifdef MUX_TR_CYCLE_EN
    cycle_d         = cycle_q;
`endif
    sel_mux_tr_ld_o = 1'b0;
    sel_mux_tr_o    = idx_q;
    tr_valid_o      = 1'b0;
    tr_idx_o        = '0;
    busy_o          = (state_q != IDLE);
    done_o          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          idx_d = '0;
`ifdef MUX_TR_CYCLE_EN
          cycle_d = cycle_i;
`endif
          if (len_i != '0) begin
            len_d   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
            state_d = LOAD;
          end else begin
            len_d   = '0;
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        sel_mux_tr_ld_o = 1'b1;
        state_d         = VALID;
      end
      VALID: begin
        tr_valid_o = 1'b1;
        tr_idx_o   = idx_q;
        if (tr_ready_i) begin
          if (!idx_at_last) begin
            // Load the next entry in the handshake cycle so the mux keeps up at 1 entry/cycle.
            sel_mux_tr_ld_o = 1'b1;
            sel_mux_tr_o    = idx_inc;
            idx_d           = idx_inc;
`ifdef MUX_TR_CYCLE_EN
          end else if (cycle_q) begin
            sel_mux_tr_ld_o = 1'b1;
            sel_mux_tr_o    = '0;
            idx_d           = '0;
            done_o          = 1'b1;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Abort wins over everything and silences this cycle's strobes.
    if (abort_i && (state_q != IDLE)) begin
      state_d         = IDLE;
      idx_d           = '0;
      sel_mux_tr_ld_o = 1'b0;
      sel_mux_tr_o    = idx_q;
      tr_valid_o      = 1'b0;
      tr_idx_o        = '0;
      done_o          = 1'b0;
    end
  end

endmodule
